// File: rtl/branch_ctrl_if.sv
// Fetch-side bus for the branch-control unit: instruction and ALU status in,
// branch-select, flag and statistics outputs back.
interface branch_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instruction;
  logic             instrValid;
  logic             aluNegative;
  logic             aluZero;
  logic             aluOverflow;
  logic             aluCarry;
  logic             rtZero;
  logic             uncondBr;
  logic             brTaken;
  logic [18:0]      condAddr19;
  logic [25:0]      brAddr26;
  logic [3:0]       flags;
  logic [CNT_W-1:0] branchCount;
  logic [CNT_W-1:0] takenCount;

  modport master (
    output instruction, instrValid, aluNegative, aluZero, aluOverflow,
           aluCarry, rtZero,
    input  uncondBr, brTaken, condAddr19, brAddr26, flags, branchCount,
           takenCount
  );

  modport slave (
    input  instruction, instrValid, aluNegative, aluZero, aluOverflow,
           aluCarry, rtZero,
    output uncondBr, brTaken, condAddr19, brAddr26, flags, branchCount,
           takenCount
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch-control unit: decodes B / CBZ / B.cond, owns the NZCV flag register
// and keeps saturating branch-statistics counters.
module branch_ctrl #(
  parameter int CNT_W = 32
) (
  input logic        clk,
  input logic        reset,
  branch_ctrl_if.slave bus
);
  logic             is_b;
  logic             is_cbz;
  logic             is_bcond;
  logic             is_flag_set;
  logic             is_branch;
  logic             cond_true;
  logic             taken;
  logic [3:0]       flag_reg;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic             n_f, z_f, v_f;

  assign is_b        = (bus.instruction[31:26] == 6'b000101);
  assign is_cbz      = (bus.instruction[31:24] == 8'b10110100);
  assign is_bcond    = (bus.instruction[31:24] == 8'b01010100);
  assign is_flag_set = (bus.instruction[31:21] == 11'b10101011000) ||
                       (bus.instruction[31:21] == 11'b11101011000);
  assign is_branch   = is_b || is_cbz || is_bcond;

  assign n_f = flag_reg[3];
  assign z_f = flag_reg[2];
  assign v_f = flag_reg[1];

  // Conditions use the registered flags; a flag setter is never a branch.
  always_comb begin
    cond_true = 1'b0;
    unique case (bus.instruction[3:0])
      4'b0000: cond_true = z_f;
      4'b0001: cond_true = !z_f;
      4'b1010: cond_true = (n_f == v_f);
      4'b1011: cond_true = (n_f != v_f);
      4'b1100: cond_true = !z_f && (n_f == v_f);
      4'b1101: cond_true = z_f || (n_f != v_f);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (!reset && bus.instrValid) begin
      if (is_b)          taken = 1'b1;
      else if (is_cbz)   taken = bus.rtZero;
      else if (is_bcond) taken = cond_true;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_reg   <= 4'b0000;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (bus.instrValid && is_flag_set)
        flag_reg <= {bus.aluNegative, bus.aluZero, bus.aluOverflow, bus.aluCarry};
      // Counters stick at all-ones rather than wrapping.
      if (bus.instrValid && is_branch && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (taken && (taken_cnt != '1))
        taken_cnt <= taken_cnt + 1'b1;
    end
  end

  assign bus.uncondBr    = is_b;
  assign bus.brTaken     = taken;
  assign bus.condAddr19  = bus.instruction[23:5];
  assign bus.brAddr26    = bus.instruction[25:0];
  assign bus.flags       = flag_reg;
  assign bus.branchCount = branch_cnt;
  assign bus.takenCount  = taken_cnt;
endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_branch_ctrl;
  localparam int CNT_W = 4;

  typedef struct {
    int         step;
    logic [31:0] ins;
    logic       expUncond;
    logic       expTaken;
    logic       chkFlags;
    logic [3:0] expFlags;
    logic       chkCnt;
    logic [CNT_W-1:0] expBc;
    logic [CNT_W-1:0] expTc;
  } exp_t;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;
  int   stepNo;
  exp_t expQ[$];

  branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  branch_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic rst, input logic [31:0] ins,
                               input logic v, input logic [3:0] alu,
                               input logic rtz, input logic expUncond,
                               input logic expTaken, input logic chkFlags,
                               input logic [3:0] expFlags, input logic chkCnt,
                               input int expBc, input int expTc);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.instruction = ins;
    bus.instrValid  = v;
    bus.aluNegative = alu[3];
    bus.aluZero     = alu[2];
    bus.aluOverflow = alu[1];
    bus.aluCarry    = alu[0];
    bus.rtZero      = rtz;
    e.step      = stepNo;
    e.ins       = ins;
    e.expUncond = expUncond;
    e.expTaken  = expTaken;
    e.chkFlags  = chkFlags;
    e.expFlags  = expFlags;
    e.chkCnt    = chkCnt;
    e.expBc     = expBc[CNT_W-1:0];
    e.expTc     = expTc[CNT_W-1:0];
    expQ.push_back(e);
    stepNo++;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [18:0] c19;
    logic [25:0] b26;
    c19 = e.ins[23:5];
    b26 = e.ins[25:0];
    testsRun++;
    if (bus.uncondBr !== e.expUncond) begin
      testsFailed++;
      $display("[TB] FAIL step%0d uncondBr got %0b want %0b", e.step, bus.uncondBr, e.expUncond);
    end
    testsRun++;
    if (bus.brTaken !== e.expTaken) begin
      testsFailed++;
      $display("[TB] FAIL step%0d brTaken got %0b want %0b", e.step, bus.brTaken, e.expTaken);
    end
    testsRun++;
    if (bus.condAddr19 !== c19 || bus.brAddr26 !== b26) begin
      testsFailed++;
      $display("[TB] FAIL step%0d addr got %h/%h want %h/%h", e.step,
               bus.condAddr19, bus.brAddr26, c19, b26);
    end
    if (e.chkFlags) begin
      testsRun++;
      if (bus.flags !== e.expFlags) begin
        testsFailed++;
        $display("[TB] FAIL step%0d flags got %b want %b", e.step, bus.flags, e.expFlags);
      end
    end
    if (e.chkCnt) begin
      testsRun++;
      if (bus.branchCount !== e.expBc) begin
        testsFailed++;
        $display("[TB] FAIL step%0d branchCount got %0d want %0d", e.step, bus.branchCount, e.expBc);
      end
      testsRun++;
      if (bus.takenCount !== e.expTc) begin
        testsFailed++;
        $display("[TB] FAIL step%0d takenCount got %0d want %0d", e.step, bus.takenCount, e.expTc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  localparam logic [31:0] B3    = 32'h14000003;
  localparam logic [31:0] CBZ2  = 32'hB4000041;
  localparam logic [31:0] SUBS  = 32'hEB020020;
  localparam logic [31:0] ADDS  = 32'hAB020020;
  localparam logic [31:0] ADD   = 32'h8B020020;
  localparam logic [31:0] BLT   = 32'h5400008B;
  localparam logic [31:0] BGE   = 32'h5400008A;
  localparam logic [31:0] BEQ   = 32'h54FFFFE0;
  localparam logic [31:0] BGT   = 32'h5400008C;
  localparam logic [31:0] BLE   = 32'h5400008D;
  localparam logic [31:0] NOP   = 32'hD503201F;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    stepNo      = 0;
    reset           = 1'b1;
    bus.instruction = 32'h0;
    bus.instrValid  = 1'b0;
    bus.aluNegative = 1'b0;
    bus.aluZero     = 1'b0;
    bus.aluOverflow = 1'b0;
    bus.aluCarry    = 1'b0;
    bus.rtZero      = 1'b0;

    //            rst  ins   v  alu(NZVC) rtz unc tkn chkF flags  chkC bc tc
    applyStimulus(1, B3,   1, 4'b0000, 0, 1, 0, 0, 4'b0000, 0, 0, 0);
    applyStimulus(0, B3,   1, 4'b0000, 0, 1, 1, 1, 4'b0000, 1, 0, 0);
    applyStimulus(0, CBZ2, 1, 4'b0000, 1, 0, 1, 1, 4'b0000, 1, 1, 1);
    applyStimulus(0, CBZ2, 1, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, 2, 2);
    applyStimulus(0, SUBS, 1, 4'b1000, 0, 0, 0, 1, 4'b0000, 1, 3, 2);
    applyStimulus(0, BLT,  1, 4'b0000, 0, 0, 1, 1, 4'b1000, 1, 3, 2);
    applyStimulus(0, BGE,  1, 4'b0000, 0, 0, 0, 1, 4'b1000, 1, 4, 3);
    applyStimulus(0, ADDS, 1, 4'b0100, 0, 0, 0, 1, 4'b1000, 1, 5, 3);
    applyStimulus(0, BEQ,  1, 4'b0000, 0, 0, 1, 1, 4'b0100, 1, 5, 3);
    applyStimulus(0, ADD,  1, 4'b1000, 0, 0, 0, 1, 4'b0100, 1, 6, 4);
    applyStimulus(0, B3,   0, 4'b0000, 0, 1, 0, 1, 4'b0100, 1, 6, 4);
    applyStimulus(0, SUBS, 0, 4'b1011, 0, 0, 0, 1, 4'b0100, 1, 6, 4);
    applyStimulus(0, BGT,  1, 4'b0000, 0, 0, 0, 1, 4'b0100, 1, 6, 4);
    applyStimulus(0, BLE,  1, 4'b0000, 0, 0, 1, 1, 4'b0100, 1, 7, 4);
    applyStimulus(0, NOP,  1, 4'b0000, 0, 0, 0, 1, 4'b0100, 1, 8, 5);

    // Twenty taken B's drive both 4-bit counters into saturation.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, B3, 1, 4'b0000, 0, 1, 1, 1, 4'b0100, 1,
                    (8 + i > 15) ? 15 : 8 + i, (5 + i > 15) ? 15 : 5 + i);
    end
    applyStimulus(1, B3,  1, 4'b0000, 0, 1, 0, 1, 4'b0100, 1, 15, 15);
    applyStimulus(0, NOP, 1, 4'b0000, 0, 0, 0, 1, 4'b0000, 1, 0, 0);

    repeat (3) @(posedge clk);
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain queue got %0d entries want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
